microwave_timer_ctrl: RTL and testbench

Control stage directly upstream of the cascaded contador_mod10 digit chain (MM:SS). Collects keypad digits into a 4-digit BCD entry register and drives the chain's data/load/stop inputs. Paces the decrement with a one-second tick and consumes the chain's all-zero flag. Runs the cook/pause/done state machine and drives the magnetron and beeper.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/tick_gen.sv | 32 +++
 rtl/microwave_timer_ctrl.sv | 122 ++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and widths for the microwave timer controller and its MM:SS BCD digit chain.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = NUM_DIGITS * BCD_W;

  // Keypad entry scrolls in from the right, like a calculator display.
  function automatic logic [DATA_W-1:0] shift_digit(input logic [DATA_W-1:0] cur,
                                                    input logic [BCD_W-1:0]  d);
    return {cur[DATA_W-BCD_W-1:0], d};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts while run is high and emits a one-cycle pulse every TICK_DIV counted cycles.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic pulse
);

  localparam int            TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_q, tick_d;

  assign pulse = run && (tick_q == LAST);

  // Holding while run is low lets a paused cook resume mid-second.
  always_comb begin
    tick_d = tick_q;
    if (clr)        tick_d = '0;
    else if (pulse) tick_d = '0;
    else if (run)   tick_d = tick_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_q <= '0;
    else        tick_q <= tick_d;
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Keypad entry, cook/pause/done sequencing and magnetron/beeper drive for the MM:SS countdown chain.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BEEP_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [BCD_W-1:0]  key_digit,
  input  logic              start_key,
  input  logic              pause_key,
  input  logic              clear_key,
  input  logic              door_closed,
  input  logic              timer_zero,
  output logic [DATA_W-1:0] data_out,
  output logic              load,
  output logic              count_en,
  output logic              mag_on,
  output logic              done_beep,
  output logic [2:0]        state_o
);

  localparam int            BW        = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] entry_q, entry_d;
  logic [BW-1:0]     beep_q, beep_d;
  logic              mag_q;
  logic              run, clr, digit_ok;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (clr),
    .pulse (count_en)
  );

  assign digit_ok  = key_valid && (key_digit <= 4'd9);
  assign data_out  = entry_q;
  assign mag_on    = mag_q;
  assign done_beep = (state_q == ST_DONE);
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    beep_d  = '0;
    load    = 1'b0;
    run     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (clear_key) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end else if (state_q == ST_ENTRY && start_key && door_closed && entry_q != '0) begin
          load    = 1'b1;
          clr     = 1'b1;
          state_d = ST_COOKING;
        end else if (digit_ok) begin
          entry_d = shift_digit(entry_q, key_digit);
          state_d = ST_ENTRY;
        end
      end
      ST_COOKING: begin
        // Zero beats a door/pause request: the countdown has already finished.
        if (clear_key) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end else if (timer_zero) begin
          state_d = ST_DONE;
        end else if (!door_closed || pause_key) begin
          state_d = ST_PAUSED;
        end else begin
          run = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (clear_key) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end else if (start_key && door_closed) begin
          state_d = ST_COOKING;
        end
      end
      ST_DONE: begin
        if (clear_key || start_key) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end else if (digit_ok) begin
          entry_d = shift_digit('0, key_digit);
          state_d = ST_ENTRY;
        end else if (beep_q == BEEP_LAST) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end else begin
          beep_d = beep_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      beep_q  <= '0;
      mag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      beep_q  <= beep_d;
      mag_q   <= (state_d == ST_COOKING);
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench: a driver pushes model-predicted outputs per cycle, a monitor pops and compares on negedge.
module tb_microwave_timer_ctrl;

  localparam int TD = 4;
  localparam int BC = 8;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start_key = 1'b0, pause_key = 1'b0, clear_key = 1'b0;
  logic        door_closed = 1'b1, timer_zero = 1'b0;
  logic [15:0] data_out;
  logic        load, count_en, mag_on, done_beep;
  logic [2:0]  state_o;

  microwave_timer_ctrl #(.TICK_DIV(TD), .BEEP_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .start_key(start_key), .pause_key(pause_key), .clear_key(clear_key),
    .door_closed(door_closed), .timer_zero(timer_zero), .data_out(data_out),
    .load(load), .count_en(count_en), .mag_on(mag_on), .done_beep(done_beep),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  st;
    logic        ld, cen, mag, beep;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // reference model state: plain integers following the behavioural rules
  int m_st = M_IDLE, m_entry = 0, m_tick = 0, m_beep = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_entry = 0; m_tick = 0; m_beep = 0;
  endtask

  // Expected outputs for the current cycle, then advance to the post-edge state.
  task automatic model_cycle(input bit kv, input int kd, input bit st, input bit pa,
                             input bit cl, input bit door, input bit tz, output exp_t e);
    int nst, nentry, ntick, nbeep;
    bit dok;
    e.data = m_entry[15:0]; e.st = m_st[2:0];
    e.mag = (m_st == M_COOK); e.beep = (m_st == M_DONE);
    e.ld = 1'b0; e.cen = 1'b0;
    nst = m_st; nentry = m_entry; ntick = m_tick; nbeep = 0;
    dok = kv && kd <= 9;
    case (m_st)
      M_IDLE, M_ENTRY: begin
        if (cl) begin nst = M_IDLE; nentry = 0; end
        else if (m_st == M_ENTRY && st && door && m_entry != 0) begin
          e.ld = 1'b1; nst = M_COOK; ntick = 0;
        end else if (dok) begin nentry = (m_entry * 16 + kd) % 65536; nst = M_ENTRY; end
      end
      M_COOK: begin
        if (cl) begin nst = M_IDLE; nentry = 0; end
        else if (tz) nst = M_DONE;
        else if (!door || pa) nst = M_PAUSE;
        else begin e.cen = (m_tick == TD - 1); ntick = (m_tick + 1) % TD; end
      end
      M_PAUSE: begin
        if (cl) begin nst = M_IDLE; nentry = 0; end
        else if (st && door) nst = M_COOK;
      end
      default: begin
        if (cl || st) begin nst = M_IDLE; nentry = 0; end
        else if (dok) begin nst = M_ENTRY; nentry = kd; end
        else if (m_beep == BC - 1) begin nst = M_IDLE; nentry = 0; end
        else nbeep = m_beep + 1;
      end
    endcase
    m_st = nst; m_entry = nentry; m_tick = ntick; m_beep = nbeep;
  endtask

  task automatic drive(input bit kv, input int kd, input bit st, input bit pa,
                       input bit cl, input bit door, input bit tz);
    exp_t e;
    @(posedge clk); #1;
    key_valid = kv; key_digit = kd[3:0]; start_key = st; pause_key = pa;
    clear_key = cl; door_closed = door; timer_zero = tz;
    model_cycle(kv, kd, st, pa, cl, door, tz, e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 15), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 4);
  endtask

  // monitor: every cycle the DUT presents its outputs, compare against the next expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state_o", state_o, e.st);
        chk("data_out", data_out, e.data);
        chk("load", load, e.ld);
        chk("count_en", count_en, e.cen);
        chk("mag_on", mag_on, e.mag);
        chk("done_beep", done_beep, e.beep);
      end
    end
  end

  initial begin
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_data", data_out, 0);
    chk("rst_load", load, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_beep", done_beep, 0);
    chk("rst_cen", count_en, 0);
    #11 reset = 1'b1;

    // 1: enter 1,3,0 and start; watch count_en cadence
    drive(1, 1, 0, 0, 0, 1, 0); drive(1, 3, 0, 0, 0, 1, 0); drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 1, 0);
    idle(9);
    // 2: door opens mid-count, then close and resume
    drive(0, 0, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 0);
    idle(6);
    // 3: chain reaches zero, beep runs to completion (zero and pause together)
    drive(0, 0, 0, 1, 0, 1, 1);
    idle(11);
    // 4: invalid digit ignored, start with zero entry does nothing
    drive(1, 11, 0, 0, 0, 1, 0); drive(0, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0); drive(0, 0, 1, 0, 0, 1, 0); drive(1, 12, 0, 0, 0, 1, 0);
    // 5: clear and start together from ENTRY
    drive(1, 5, 0, 0, 0, 1, 0); drive(0, 0, 1, 0, 1, 1, 0);
    idle(2);
    // full-range entry 99:99, then key press ends a beep early
    drive(1, 9, 0, 0, 0, 1, 0); drive(1, 9, 0, 0, 0, 1, 0);
    drive(1, 9, 0, 0, 0, 1, 0); drive(1, 9, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 1, 0); idle(3); drive(0, 0, 0, 0, 0, 1, 1);
    idle(2); drive(1, 7, 0, 0, 0, 1, 0); idle(2);

    rand_cycles(3000);

    // 6: asynchronous reset mid-cook
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(1, 2, 0, 0, 0, 1, 0); drive(0, 0, 1, 0, 0, 1, 0);
    idle(2);
    @(negedge clk); #1;
    chk("pre_rst_mag", mag_on, (m_st == M_COOK));
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_mag", mag_on, 0);
    chk("arst_cen", count_en, 0);
    chk("arst_load", load, 0);
    chk("arst_beep", done_beep, 0);
    chk("arst_state", state_o, 0);
    chk("arst_data", data_out, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    rand_cycles(300);

    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
